// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the CNN input path.
//   DEFAULT_*      : default image geometry, pixel and coordinate widths
//                    (also used by conv2d_layer).
//   pixel_t        : one pixel of DEFAULT_PIX_W bits.
//   loader_state_e : image_loader FSM encoding (IDLE=0, LOAD=1, FULL=2).
package cnn_pkg;

   localparam int unsigned DEFAULT_IMG_W   = 8;
   localparam int unsigned DEFAULT_IMG_H   = 8;
   localparam int unsigned DEFAULT_PIX_W   = 8;
   localparam int unsigned DEFAULT_COORD_W = 5;

   typedef logic [DEFAULT_PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StFull = 2'd2
   } loader_state_e;

endpackage

// File: rtl/frame_buffer.sv
// frame_buffer: DEPTH x WIDTH register array holding one image.
//   clk   : clock
//   we    : write enable
//   waddr : write address (linear raster index)
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : data at raddr
// Contents are deliberately not reset.
module frame_buffer
   import cnn_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_IMG_W * DEFAULT_IMG_H,
   parameter int unsigned WIDTH  = DEFAULT_PIX_W,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/image_loader.sv
// image_loader: receives a raster-order byte stream into a frame buffer,
// announces the complete frame, serves zero-padded reads until released.
//   clk, reset    : clock, asynchronous active-high reset
//   in_data       : incoming pixel byte
//   in_valid      : in_data valid this cycle
//   in_ready      : loader accepts a byte this cycle (registered)
//   loading_done  : level, frame complete and held
//   start_pulse   : one-cycle pulse on entry to FULL
//   release_frame : consumer done with frame, return to IDLE
//   rd_x, rd_y    : signed read coordinates
//   rd_pixel      : combinational pixel at (rd_x, rd_y), 0 outside image or when not FULL
//   pix_count     : bytes accepted in the current frame
module image_loader
   import cnn_pkg::*;
#(
   parameter int unsigned IMG_W   = DEFAULT_IMG_W,
   parameter int unsigned IMG_H   = DEFAULT_IMG_H,
   parameter int unsigned PIX_W   = DEFAULT_PIX_W,
   parameter int unsigned COORD_W = DEFAULT_COORD_W
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [PIX_W-1:0]                     in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic                                 loading_done,
   output logic                                 start_pulse,
   input  logic                                 release_frame,
   input  logic signed [COORD_W-1:0]            rd_x,
   input  logic signed [COORD_W-1:0]            rd_y,
   output logic [PIX_W-1:0]                     rd_pixel,
   output logic [$clog2(IMG_W*IMG_H+1)-1:0]     pix_count
);

   localparam int unsigned FRAME  = IMG_W * IMG_H;
   localparam int unsigned CNT_W  = $clog2(FRAME + 1);
   localparam int unsigned ADDR_W = $clog2(FRAME);

   localparam logic [CNT_W-1:0]          LAST_IDX = CNT_W'(FRAME - 1);
   localparam logic signed [COORD_W-1:0] X_LIM    = COORD_W'(IMG_W);
   localparam logic signed [COORD_W-1:0] Y_LIM    = COORD_W'(IMG_H);

   loader_state_e     state;
   logic              accept;
   logic              rd_in_range;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  buf_rdata;

   // in_ready is only ever high in IDLE/LOAD, so accept implies a legal write.
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= StIdle;
         in_ready     <= 1'b0;
         loading_done <= 1'b0;
         start_pulse  <= 1'b0;
         pix_count    <= '0;
      end else begin
         start_pulse <= 1'b0;
         unique case (state)
            StIdle: begin
               // in_ready comes out of reset low; raise it on the first idle clock.
               in_ready <= 1'b1;
               if (accept) begin
                  pix_count <= CNT_W'(1);
                  state     <= StLoad;
               end
            end
            StLoad: begin
               if (accept) begin
                  pix_count <= pix_count + CNT_W'(1);
                  if (pix_count == LAST_IDX) begin
                     state        <= StFull;
                     in_ready     <= 1'b0;
                     loading_done <= 1'b1;
                     start_pulse  <= 1'b1;
                  end
               end
            end
            StFull: begin
               if (release_frame) begin
                  state        <= StIdle;
                  in_ready     <= 1'b1;
                  loading_done <= 1'b0;
                  pix_count    <= '0;
               end
            end
            default: begin
               state    <= StIdle;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

   // Bounds are checked on the signed coordinates; the address is only
   // meaningful when rd_in_range holds, otherwise the output is forced to 0.
   assign rd_in_range = !rd_x[COORD_W-1] && (rd_x < X_LIM) &&
                        !rd_y[COORD_W-1] && (rd_y < Y_LIM);
   assign rd_addr     = ADDR_W'(int'(rd_y) * int'(IMG_W) + int'(rd_x));
   assign rd_pixel    = (state == StFull && rd_in_range) ? buf_rdata : '0;

   frame_buffer #(
      .DEPTH  (FRAME),
      .WIDTH  (PIX_W),
      .ADDR_W (ADDR_W)
   ) u_frame_buffer (
      .clk   (clk),
      .we    (accept),
      .waddr (pix_count[ADDR_W-1:0]),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (buf_rdata)
   );

endmodule
